// File: rtl/alu_seq.sv
// alu_seq: sequenced ALU with a valid/ready handshake, registered result and C/V/N/Z flags.
// Define ALU_SEQ_DECIMAL_EN to compile in the ADJ state for BCD ADD/SUB.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic             alu_decimal,
  input  logic [WIDTH-1:0] alu_AI,
  input  logic [WIDTH-1:0] alu_BI,
  input  logic             alu_carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_Y,
  output logic             alu_carry_out,
  output logic             alu_overflow,
  output logic             alu_negative,
  output logic             alu_zero
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SR  = 3'b101;
  localparam logic [2:0] OP_SL  = 3'b110;

`ifdef ALU_SEQ_DECIMAL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ADJ = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             c_q, c_d, v_q, v_d, n_q, n_d, z_q, z_d;
  logic [WIDTH+1:0] bin_res;

  // Returns {V, C, Y} for the binary interpretation of an opcode.
  function automatic logic [WIDTH+1:0] alu_bin(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b, input logic cin);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] y;
    logic             c, v;
    sum = '0;
    y   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        y   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, cin};
        y   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SR: begin
        y = {cin, a[WIDTH-1:1]};
        c = a[0];
      end
      OP_SL: begin
        y = {a[WIDTH-2:0], cin};
        c = a[WIDTH-1];
      end
      default: y = a;
    endcase
    return {v, c, y};
  endfunction

  assign bin_res = alu_bin(alu_control, alu_AI, alu_BI, alu_carry_in);

`ifdef ALU_SEQ_DECIMAL_EN
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d, sub_q, sub_d;
  logic [WIDTH:0]   dec_res;
  logic             dec_req;

  // Nibble-serial BCD adjust; the digit carry chain replaces the binary one.
  function automatic logic [WIDTH:0] dec_calc(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic cin, input logic sub);
    logic [4:0]       s;
    logic [WIDTH-1:0] y;
    logic             c;
    c = cin;
    y = '0;
    for (int i = 0; i < WIDTH / 4; i++) begin
      s = {1'b0, a[4*i +: 4]} + {1'b0, (sub ? ~b[4*i +: 4] : b[4*i +: 4])} + {4'b0000, c};
      if (!sub) begin
        c = (s > 5'd9);
        if (c) s = s + 5'd6;
      end else begin
        c = s[4];
        if (!c) s = s - 5'd6;
      end
      y[4*i +: 4] = s[3:0];
    end
    return {c, y};
  endfunction

  assign dec_req = alu_decimal && ((alu_control == OP_ADD) || (alu_control == OP_SUB));
  assign dec_res = dec_calc(a_q, b_q, cin_q, sub_q);
`else
  logic unused_decimal;
  assign unused_decimal = alu_decimal;
`endif

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    c_d     = c_q;
    v_d     = v_q;
    n_d     = n_q;
    z_d     = z_q;
`ifdef ALU_SEQ_DECIMAL_EN
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = DONE;
          y_d     = bin_res[WIDTH-1:0];
          c_d     = bin_res[WIDTH];
          v_d     = bin_res[WIDTH+1];
          n_d     = bin_res[WIDTH-1];
          z_d     = (bin_res[WIDTH-1:0] == '0);
`ifdef ALU_SEQ_DECIMAL_EN
          // V_q keeps the binary overflow; ADJ only rewrites Y, C, N, Z.
          if (dec_req) begin
            state_d = ADJ;
            a_d     = alu_AI;
            b_d     = alu_BI;
            cin_d   = alu_carry_in;
            sub_d   = alu_control[0];
          end
`endif
        end
      end
`ifdef ALU_SEQ_DECIMAL_EN
      ADJ: begin
        state_d = DONE;
        y_d     = dec_res[WIDTH-1:0];
        c_d     = dec_res[WIDTH];
        n_d     = dec_res[WIDTH-1];
        z_d     = (dec_res[WIDTH-1:0] == '0);
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      y_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
`ifdef ALU_SEQ_DECIMAL_EN
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      c_q     <= c_d;
      v_q     <= v_d;
      n_q     <= n_d;
      z_q     <= z_d;
`ifdef ALU_SEQ_DECIMAL_EN
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      sub_q   <= sub_d;
`endif
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign alu_Y         = y_q;
  assign alu_carry_out = c_q;
  assign alu_overflow  = v_q;
  assign alu_negative  = n_q;
  assign alu_zero      = z_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: 8-bit and 16-bit instances against an arithmetic reference model.
module tb_alu_seq;

`ifdef ALU_SEQ_DECIMAL_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] y;
    logic        c, v, n, z;
  } res_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic       iv8 = 0, dec8 = 0, cin8 = 0, ordy8 = 0;
  logic [2:0] ctl8 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic       ir8, ov8, co8, vo8, no8, zo8;
  logic [7:0] y8;

  logic        iv16 = 0, dec16 = 0, cin16 = 0, ordy16 = 0;
  logic [2:0]  ctl16 = 0;
  logic [15:0] a16 = 0, b16 = 0;
  logic        ir16, ov16, co16, vo16, no16, zo16;
  logic [15:0] y16;

  int n_chk = 0;
  int n_pass = 0;

  alu_seq #(.WIDTH(8)) u8 (
    .clk(clk), .resetn(resetn), .in_valid(iv8), .in_ready(ir8), .alu_control(ctl8),
    .alu_decimal(dec8), .alu_AI(a8), .alu_BI(b8), .alu_carry_in(cin8), .out_valid(ov8),
    .out_ready(ordy8), .alu_Y(y8), .alu_carry_out(co8), .alu_overflow(vo8),
    .alu_negative(no8), .alu_zero(zo8)
  );

  alu_seq #(.WIDTH(16)) u16 (
    .clk(clk), .resetn(resetn), .in_valid(iv16), .in_ready(ir16), .alu_control(ctl16),
    .alu_decimal(dec16), .alu_AI(a16), .alu_BI(b16), .alu_carry_in(cin16), .out_valid(ov16),
    .out_ready(ordy16), .alu_Y(y16), .alu_carry_out(co16), .alu_overflow(vo16),
    .alu_negative(no16), .alu_zero(zo16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic bit is_dec(input logic [2:0] op, input logic dec);
    return DEC_EN && dec && (op <= 3'd1);
  endfunction

  function automatic res_t model(input int w, input logic [2:0] op, input logic dec,
                                 input longint a, input longint b, input logic cin);
    res_t   r;
    longint mask, s, ci, y, t, carry, da, db;
    longint am, bm, ym;
    mask = (longint'(1) << w) - 1;
    ci   = longint'(cin);
    r    = '0;
    y    = 0;
    case (op)
      3'd0: begin
        s = a + b + ci; y = s & mask; r.c = ((s >> w) & 1) != 0;
        am = (a >> (w-1)) & 1; bm = (b >> (w-1)) & 1; ym = (y >> (w-1)) & 1;
        r.v = (am == bm) && (ym != am);
      end
      3'd1: begin
        s = a + ((~b) & mask) + ci; y = s & mask; r.c = ((s >> w) & 1) != 0;
        am = (a >> (w-1)) & 1; bm = (b >> (w-1)) & 1; ym = (y >> (w-1)) & 1;
        r.v = (am != bm) && (ym != am);
      end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: begin y = (ci << (w-1)) | (a >> 1); r.c = (a & 1) != 0; end
      3'd6: begin y = ((a << 1) | ci) & mask; r.c = ((a >> (w-1)) & 1) != 0; end
      default: y = a;
    endcase
    if (is_dec(op, dec)) begin
      carry = ci;
      y = 0;
      for (int d = 0; d < w / 4; d++) begin
        da = (a >> (4*d)) & 15;
        db = (b >> (4*d)) & 15;
        if (op == 3'd0) begin
          t = da + db + carry;
          if (t > 9) begin t = t + 6; carry = 1; end else carry = 0;
        end else begin
          t = da - db - (1 - carry);
          if (t < 0) begin t = t + 10; carry = 0; end else carry = 1;
        end
        y = y | ((t & 15) << (4*d));
      end
      r.c = (carry != 0);
    end
    r.y = y[31:0];
    r.n = ((y >> (w-1)) & 1) != 0;
    r.z = (y == 0);
    return r;
  endfunction

  task automatic run8(input logic [2:0] op, input logic dec, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input int hold);
    res_t e;
    int   lat;
    e = model(8, op, dec, longint'(a), longint'(b), cin);
    chk("ready_idle8", ir8, 1);
    iv8 = 1; ctl8 = op; dec8 = dec; a8 = a; b8 = b; cin8 = cin;
    @(posedge clk); #1;
    iv8 = 0; ctl8 = 3'($urandom); dec8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
    cin8 = 1'($urandom);
    lat = 1;
    while (!ov8 && lat < 6) begin @(posedge clk); #1; lat++; end
    chk("latency8", lat, is_dec(op, dec) ? 2 : 1);
    for (int i = 0; i < hold; i++) begin
      iv8 = 1; ctl8 = 3'($urandom); dec8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      @(posedge clk); #1;
      chk("hold_ready8", ir8, 0);
      chk("hold_valid8", ov8, 1);
      chk("hold_y8", y8, e.y);
      chk("hold_flags8", {co8, vo8, no8, zo8}, {e.c, e.v, e.n, e.z});
    end
    iv8 = 0;
    chk("y8", y8, e.y);
    chk("c8", co8, e.c);
    chk("v8", vo8, e.v);
    chk("n8", no8, e.n);
    chk("z8", zo8, e.z);
    ordy8 = 1;
    @(posedge clk); #1;
    ordy8 = 0;
    chk("drop_valid8", ov8, 0);
  endtask

  task automatic run16(input logic [2:0] op, input logic dec, input logic [15:0] a, input logic [15:0] b,
                       input logic cin);
    res_t e;
    int   lat;
    e = model(16, op, dec, longint'(a), longint'(b), cin);
    iv16 = 1; ctl16 = op; dec16 = dec; a16 = a; b16 = b; cin16 = cin;
    @(posedge clk); #1;
    iv16 = 0; a16 = 16'($urandom); b16 = 16'($urandom);
    lat = 1;
    while (!ov16 && lat < 6) begin @(posedge clk); #1; lat++; end
    chk("latency16", lat, is_dec(op, dec) ? 2 : 1);
    chk("y16", y16, e.y);
    chk("flags16", {co16, vo16, no16, zo16}, {e.c, e.v, e.n, e.z});
    ordy16 = 1;
    @(posedge clk); #1;
    ordy16 = 0;
    chk("drop_valid16", ov16, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_valid8", ov8, 0);
    chk("rst_ready8", ir8, 1);
    chk("rst_y8", y8, 0);
    chk("rst_flags8", {co8, vo8, no8, zo8}, 0);
    chk("rst_valid16", ov16, 0);
    chk("rst_y16", y16, 0);
    @(posedge clk); #1;
    resetn = 1;
    @(posedge clk); #1;

    run8(3'd0, 1'b0, 8'h7F, 8'h01, 1'b0, 0);
    run8(3'd1, 1'b0, 8'h00, 8'h01, 1'b1, 0);
    run8(3'd5, 1'b0, 8'h01, 8'h00, 1'b1, 0);
    run8(3'd0, 1'b1, 8'h58, 8'h46, 1'b1, 0);
    run8(3'd1, 1'b1, 8'h10, 8'h01, 1'b1, 0);
    run8(3'd2, 1'b1, 8'hF0, 8'h3C, 1'b0, 0);
    run8(3'd6, 1'b0, 8'h80, 8'h00, 1'b0, 0);
    run8(3'd4, 1'b0, 8'hA5, 8'h5A, 1'b1, 5);

    for (int k = 0; k < 40; k++)
      run8(3'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

    run16(3'd0, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
    run16(3'd0, 1'b1, 16'h0999, 16'h0001, 1'b0);
    for (int k = 0; k < 8; k++)
      run16(3'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));

    // Abort a decimal operation in flight; nothing may surface afterwards.
    iv8 = 1; ctl8 = 3'd0; dec8 = 1; a8 = 8'h58; b8 = 8'h46; cin8 = 1;
    @(posedge clk); #1;
    iv8 = 0;
    #2 resetn = 0;
    #1;
    chk("abort_valid8", ov8, 0);
    chk("abort_y8", y8, 0);
    chk("abort_flags8", {co8, vo8, no8, zo8}, 0);
    chk("abort_ready8", ir8, 1);
    @(posedge clk); #1;
    resetn = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_abort_valid8", ov8, 0);
      chk("post_abort_ready8", ir8, 1);
      chk("post_abort_y8", y8, 0);
    end
    run8(3'd3, 1'b0, 8'h0F, 8'hF0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand/result width in bits; legal values are multiples of 4, 8 to 32.
REQ-002 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-003 resetn  input  1  reset; SHALL be asynchronous and active-low.
REQ-004 in_valid  input  1  operation request.
REQ-005 in_ready  output  1  block can accept an operation.
REQ-006 alu_control  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SR, 110 SL, 111 PASS.
REQ-007 alu_decimal  input  1  BCD mode request for ADD/SUB.
REQ-008 alu_AI, alu_BI  input  WIDTH  operands.
REQ-009 alu_carry_in  input  1  carry/borrow-not in, shift fill bit.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 alu_Y  output  WIDTH  registered result.
REQ-013 alu_carry_out, alu_overflow, alu_negative, alu_zero  output  1 each  registered C, V, N, Z flags.

Function
REQ-014 The FSM SHALL have states IDLE, ADJ, DONE; in_ready SHALL be 1 exactly in IDLE.
REQ-015 Accept = in_valid && in_ready; alu_control, alu_decimal, operands and alu_carry_in SHALL be sampled only on accept and ignored otherwise.
REQ-016 Binary op: accept in IDLE -> DONE at next edge with result registered; out_valid SHALL assert 1 cycle after accept.
REQ-017 Decimal ADD/SUB: IDLE -> ADJ -> DONE; out_valid SHALL assert 2 cycles after accept.
REQ-018 In DONE, out_valid=1; alu_Y and flags SHALL stay stable until out_ready=1, then DONE -> IDLE at that edge (out_valid 0 next cycle).
REQ-019 ADD: Y = (A+B+Cin) mod 2^WIDTH; C = bit WIDTH of sum; V = (A[msb]==B[msb]) && (Y[msb]!=A[msb]).
REQ-020 SUB: Y = A + ~B + Cin (Cin=1 means no borrow); C=1 when no borrow; V = (A[msb]!=B[msb]) && (Y[msb]!=A[msb]).
REQ-021 AND/OR/XOR/PASS: Y = A&B, A|B, A^B, A respectively; C=0, V=0.
REQ-022 SR: Y = {Cin, A[WIDTH-1:1]}, C = A[0]; SL: Y = {A[WIDTH-2:0], Cin}, C = A[WIDTH-1]; V=0 for both.
REQ-023 N SHALL equal final Y[msb]; Z SHALL be 1 iff final Y == 0.
REQ-024 Decimal adjust (ADD): per nibble low to high, add 6 if nibble > 9 or nibble carry occurred, propagate carry; C = carry out of top nibble; V from binary intermediate (REQ-019).
REQ-025 Decimal adjust (SUB): per nibble, subtract 6 where a nibble borrow occurred; C=1 when no decimal borrow; V from binary intermediate (REQ-020).
REQ-026 Non-BCD operand digits SHALL be processed by the REQ-024/025 algorithm without error indication.
REQ-027 alu_decimal with non-ADD/SUB opcode SHALL be ignored (binary path, 1-cycle latency).
REQ-028 in_valid in ADJ or DONE SHALL not be accepted; requester holds it.

Reset
REQ-029 resetn low SHALL immediately force IDLE, out_valid=0, alu_Y=0, all flags 0; in_ready=1 while in IDLE.
REQ-030 Reset asserted in ADJ or DONE SHALL abort the operation; no result SHALL be delivered after release.

Configuration
REQ-031 Macro ALU_SEQ_DECIMAL_EN defined: ADJ state and REQ-024/025 logic compiled in.
REQ-032 Macro ALU_SEQ_DECIMAL_EN undefined: ADJ state absent, alu_decimal ignored, all ops binary with 1-cycle latency.

Verification
REQ-033 WIDTH=8, ADD A=0x7F B=0x01 Cin=0 -> Y=0x80, C=0, V=1, N=1, Z=0, out_valid 1 cycle after accept.
REQ-034 WIDTH=8, SUB A=0x00 B=0x01 Cin=1 -> Y=0xFF, C=0, V=0, N=1; SR A=0x01 Cin=1 -> Y=0x80, C=1.
REQ-035 DECIMAL_EN, ADD decimal A=0x58 B=0x46 Cin=1 -> Y=0x05, C=1, out_valid 2 cycles after accept; SUB decimal A=0x10 B=0x01 Cin=1 -> Y=0x09, C=1.
REQ-036 Hold out_ready=0 for 5 cycles in DONE while toggling operands and in_valid -> alu_Y/flags unchanged, in_ready=0, no accept.
REQ-037 Assert resetn=0 during ADJ -> out_valid=0, Y=0, flags 0 immediately; after release, in_ready=1 and no stale result.
REQ-038 WIDTH=16, ADD A=0xFFFF B=0x0001 Cin=0 -> Y=0x0000, C=1, Z=1, V=0.
